// File: rtl/color_detect_pkg.sv
// Shared types and constants for the color-detect hue path.
package color_detect_pkg;

   // Which channel holds the pixel maximum; GRAY marks an achromatic pixel.
   typedef enum logic [1:0] {
      SECT_R    = 2'd0,
      SECT_G    = 2'd1,
      SECT_B    = 2'd2,
      SECT_GRAY = 2'd3
   } sector_t;

   localparam int HUE_OFS_R     = 0;
   localparam int HUE_OFS_G     = 120;
   localparam int HUE_OFS_B     = 240;
   localparam int HUE_FRAC_BITS = 8;
   localparam int HUE_MAX       = 360;

   // Sector offset in degrees, pre-shifted into the Q.8 domain of the scaled quotient.
   function automatic logic [17:0] hue_ofs_fixed(input sector_t s);
      logic [17:0] ofs;
      case (s)
         SECT_G:  ofs = 18'(HUE_OFS_G << HUE_FRAC_BITS);
         SECT_B:  ofs = 18'(HUE_OFS_B << HUE_FRAC_BITS);
         default: ofs = 18'(HUE_OFS_R << HUE_FRAC_BITS);
      endcase
      return ofs;
   endfunction

endpackage

// File: rtl/hue_tag_fifo.sv
// Synchronous tag FIFO. A pop is honoured only when the FIFO held data before
// this cycle (no push-to-pop bypass); a push into a full FIFO is honoured only
// when a pop frees a slot in the same cycle. Rejected operations raise a
// one-cycle overflow/underflow strobe.
module hue_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 32,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok, full;

   // Accept/reject decisions and next pointer/occupancy values.
   always_comb begin
      full        = (count_q == LVL_W'(DEPTH));
      pop_ok      = i_pop && (count_q != '0);
      push_ok     = i_push && (!full || pop_ok);
      wr_ptr_d    = wr_ptr_q + AW'(push_ok);
      rd_ptr_d    = rd_ptr_q + AW'(pop_ok);
      count_d     = count_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
      o_overflow  = i_push && !push_ok;
      o_underflow = i_pop && !pop_ok;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[rd_ptr_q];
   assign o_empty = (count_q == '0);
   assign o_level = count_q;

endmodule

// File: rtl/hue_stage2.sv
// Hue stage 2: pairs each stage1 quotient with its queued sector tag, scales
// by 60 degrees, adds the sector offset and wraps into 0..359.
// Build option: define HUE_STAGE2_ROUND_EN to round half up to integer
// degrees; otherwise the fractional part is floored.
module hue_stage2
   import color_detect_pkg::*;
#(
   parameter int TAG_DEPTH = 32
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_tag_valid,
   input  logic [1:0]                       i_sector,
   input  logic                             i_quot_valid,
   input  logic [15:0]                      i_quot,
   output logic [8:0]                       o_hue,
   output logic                             o_valid,
   output logic                             o_err,
   output logic [$clog2(TAG_DEPTH+1)-1:0]   o_tag_level
);

   localparam int LVL_W = $clog2(TAG_DEPTH + 1);

   logic [1:0]       tag_rdata;
   logic             tag_empty, tag_ovf, tag_unf, pop_ok;
   logic [LVL_W-1:0] tag_level;

   hue_tag_fifo #(
      .WIDTH (2),
      .DEPTH (TAG_DEPTH),
      .LVL_W (LVL_W)
   ) u_tag_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (i_tag_valid),
      .i_wdata     (i_sector),
      .i_pop       (i_quot_valid),
      .o_rdata     (tag_rdata),
      .o_empty     (tag_empty),
      .o_level     (tag_level),
      .o_overflow  (tag_ovf),
      .o_underflow (tag_unf)
   );

   // Stage A: clamped quotient with its sector.
   logic               a_valid_q, a_valid_d;
   logic signed [9:0]  a_quot_q, a_quot_d;
   sector_t            a_sector_q, a_sector_d;
   // Stage B: scaled quotient plus sector offset, Q.8 degrees.
   logic               b_valid_q, b_valid_d;
   logic signed [17:0] b_sum_q, b_sum_d;
   sector_t            b_sector_q, b_sector_d;
   // Stage C: output registers.
   logic               o_valid_q, o_valid_d;
   logic [8:0]         o_hue_q, o_hue_d;
   logic               err_q, err_d;

   logic signed [15:0] quot_s;
   logic signed [9:0]  quot_clamp;
   logic signed [21:0] prod;
   logic signed [17:0] rnd;
   logic signed [17:0] deg;
   logic signed [17:0] wrapped;

   // Stage A: pop the tag and clamp the quotient to +/-1.0.
   always_comb begin
      pop_ok = i_quot_valid && !tag_empty;
      quot_s = $signed(i_quot);
      if (quot_s > 16'sd256) begin
         quot_clamp = 10'sd256;
      end else if (quot_s < -16'sd256) begin
         quot_clamp = -10'sd256;
      end else begin
         quot_clamp = quot_s[9:0];
      end
      a_valid_d  = pop_ok;
      a_quot_d   = pop_ok ? quot_clamp : a_quot_q;
      a_sector_d = pop_ok ? sector_t'(tag_rdata) : a_sector_q;
   end

   // Stage B: scale by 60 and add the sector offset.
   always_comb begin
      prod       = a_quot_q * 22'sd60;
      b_valid_d  = a_valid_q;
      b_sum_d    = a_valid_q ? $signed(prod[17:0] + hue_ofs_fixed(a_sector_q)) : b_sum_q;
      b_sector_d = a_valid_q ? a_sector_q : b_sector_q;
   end

   // Stage C: drop the fraction, wrap into 0..359, force gray to 0.
   always_comb begin
`ifdef HUE_STAGE2_ROUND_EN
      rnd = b_sum_q + 18'sd128;
`else
      rnd = b_sum_q;
`endif
      deg = rnd >>> HUE_FRAC_BITS;
      if (deg < 18'sd0) begin
         wrapped = deg + 18'(HUE_MAX);
      end else if (deg >= 18'(HUE_MAX)) begin
         wrapped = deg - 18'(HUE_MAX);
      end else begin
         wrapped = deg;
      end
      o_valid_d = b_valid_q;
      if (!b_valid_q) begin
         o_hue_d = o_hue_q;
      end else if (b_sector_q == SECT_GRAY) begin
         o_hue_d = 9'd0;
      end else begin
         o_hue_d = wrapped[8:0];
      end
      err_d = err_q || tag_ovf || tag_unf;
   end

   // Pipeline and sticky error registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_valid_q  <= 1'b0;
         a_quot_q   <= '0;
         a_sector_q <= SECT_R;
         b_valid_q  <= 1'b0;
         b_sum_q    <= '0;
         b_sector_q <= SECT_R;
         o_valid_q  <= 1'b0;
         o_hue_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         a_valid_q  <= a_valid_d;
         a_quot_q   <= a_quot_d;
         a_sector_q <= a_sector_d;
         b_valid_q  <= b_valid_d;
         b_sum_q    <= b_sum_d;
         b_sector_q <= b_sector_d;
         o_valid_q  <= o_valid_d;
         o_hue_q    <= o_hue_d;
         err_q      <= err_d;
      end
   end

   assign o_hue       = o_hue_q;
   assign o_valid     = o_valid_q;
   assign o_err       = err_q;
   assign o_tag_level = tag_level;

endmodule

// File: tb/tb_hue_stage2.sv
// Testbench for hue_stage2: directed vectors, expected hues queued at issue
// time and compared (value and arrival cycle) by an output monitor.
module tb_hue_stage2;

   localparam int TAG_DEPTH = 32;
   localparam int LVL_W     = $clog2(TAG_DEPTH + 1);

`ifdef HUE_STAGE2_ROUND_EN
   localparam logic [8:0] G_THIRD_EXP = 9'd140;
   localparam logic [8:0] R_TINY_EXP  = 9'd0;
`else
   localparam logic [8:0] G_THIRD_EXP = 9'd139;
   localparam logic [8:0] R_TINY_EXP  = 9'd359;
`endif

   logic             clk;
   logic             rst;
   logic             tag_valid;
   logic [1:0]       sector;
   logic             quot_valid;
   logic [15:0]      quot;
   logic [8:0]       hue;
   logic             out_valid;
   logic             err;
   logic [LVL_W-1:0] tag_level;

   hue_stage2 #(.TAG_DEPTH(TAG_DEPTH)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_tag_valid  (tag_valid),
      .i_sector     (sector),
      .i_quot_valid (quot_valid),
      .i_quot       (quot),
      .o_hue        (hue),
      .o_valid      (out_valid),
      .o_err        (err),
      .o_tag_level  (tag_level)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard
   logic [8:0] exp_q[$];
   int         exp_cyc_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every o_valid must match the oldest expected result and arrive on time.
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got o_valid=1 hue=%0d, required no result (cycle %0d)", hue, cyc);
         end else begin
            logic [8:0] e;
            int         ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("hue_value", int'(hue), int'(e));
            check("hue_arrival_cycle", cyc, ec);
         end
      end
   end

   // Driver: called at a negedge; drives one cycle of inputs and returns at the next negedge.
   task automatic drive(input logic tv, input logic [1:0] sec, input logic qv,
                        input logic [15:0] q, input logic want, input logic [8:0] exp_hue);
      tag_valid  = tv;
      sector     = sec;
      quot_valid = qv;
      quot       = q;
      if (want) begin
         exp_q.push_back(exp_hue);
         exp_cyc_q.push_back(cyc + 3);
      end
      @(negedge clk);
      tag_valid  = 1'b0;
      quot_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [1:0]  six_sec [6];
   logic [15:0] six_quot[6];
   logic [8:0]  six_exp [6];

   initial begin
      six_sec[0] = 2'd0; six_quot[0] = 16'h0080; six_exp[0] = 9'd30;
      six_sec[1] = 2'd1; six_quot[1] = 16'hFF80; six_exp[1] = 9'd90;
      six_sec[2] = 2'd2; six_quot[2] = 16'h0040; six_exp[2] = 9'd255;
      six_sec[3] = 2'd3; six_quot[3] = 16'hFFFF; six_exp[3] = 9'd0;
      six_sec[4] = 2'd2; six_quot[4] = 16'h7FFF; six_exp[4] = 9'd300;
      six_sec[5] = 2'd0; six_quot[5] = 16'hFFFF; six_exp[5] = R_TINY_EXP;

      rst        = 1'b1;
      tag_valid  = 1'b0;
      sector     = 2'd0;
      quot_valid = 1'b0;
      quot       = 16'h0000;

      // Reset for 5 cycles, with a quotient pulse inside it that must be ignored
      idle(2);
      drive(1'b0, 2'd0, 1'b1, 16'h0100, 1'b0, 9'd0);
      idle(2);
      check("reset_hue", int'(hue), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_err", int'(err), 0);
      check("reset_level", int'(tag_level), 0);
      rst = 1'b0;
      idle(2);
      check("post_reset_err", int'(err), 0);

      // Sector R, quotient -2.5 clamps to -1.0
      drive(1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 9'd0);
      check("level_after_one_push", int'(tag_level), 1);
      drive(1'b0, 2'd0, 1'b1, 16'hFD80, 1'b1, 9'd300);
      idle(4);

      // Sector G, quotient about 1/3
      drive(1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 9'd0);
      drive(1'b0, 2'd0, 1'b1, 16'h0055, 1'b1, G_THIRD_EXP);
      idle(4);

      // Back-to-back results
      drive(1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 9'd0);
      drive(1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 9'd0);
      drive(1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 9'd0);
      drive(1'b0, 2'd0, 1'b1, 16'h0000, 1'b1, 9'd240);
      drive(1'b0, 2'd0, 1'b1, 16'h0100, 1'b1, 9'd0);
      drive(1'b0, 2'd0, 1'b1, 16'h0100, 1'b1, 9'd60);
      idle(5);
      check("b2b_level", int'(tag_level), 0);
      check("b2b_err", int'(err), 0);

      // Six tags well ahead of their quotients
      for (int i = 0; i < 6; i++) drive(1'b1, six_sec[i], 1'b0, 16'h0000, 1'b0, 9'd0);
      check("six_level_peak", int'(tag_level), 6);
      idle(15);
      check("six_level_held", int'(tag_level), 6);
      for (int i = 0; i < 6; i++) drive(1'b0, 2'd0, 1'b1, six_quot[i], 1'b1, six_exp[i]);
      check("six_level_drained", int'(tag_level), 0);
      idle(5);
      check("six_err", int'(err), 0);

      // Underflow: quotient with empty FIFO
      drive(1'b0, 2'd0, 1'b1, 16'h0100, 1'b0, 9'd0);
      check("underflow_err", int'(err), 1);
      idle(10);
      check("underflow_err_sticky", int'(err), 1);
      check("underflow_level", int'(tag_level), 0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      check("err_cleared_by_reset", int'(err), 0);

      // Fill to capacity, then full with simultaneous pop, then overflow
      for (int i = 0; i < TAG_DEPTH; i++) drive(1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 9'd0);
      check("full_level", int'(tag_level), TAG_DEPTH);
      check("full_err", int'(err), 0);
      drive(1'b1, 2'd2, 1'b1, 16'h0000, 1'b1, 9'd240);
      check("full_push_pop_level", int'(tag_level), TAG_DEPTH);
      check("full_push_pop_err", int'(err), 0);
      drive(1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 9'd0);
      check("overflow_err", int'(err), 1);
      check("overflow_level", int'(tag_level), TAG_DEPTH);
      idle(5);

      // Reset with tags queued: FIFO empties, later quotient is an underflow
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      check("midreset_level", int'(tag_level), 0);
      check("midreset_err", int'(err), 0);
      drive(1'b0, 2'd0, 1'b1, 16'h0100, 1'b0, 9'd0);
      idle(5);
      check("stale_quot_err", int'(err), 1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
